// File: rtl/sprite_blit_writer.sv
// Sprite-sheet to framebuffer blitter: raster-scans an SPR_W x SPR_H window of a ROM sheet and writes it clipped into the framebuffer.
// Optional macro BLIT_TRANSPARENCY_EN: palette index 0 is treated as transparent and never written.
module sprite_blit_writer #(
    parameter int SHEET_WIDTH = 926,
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 240,
    parameter int ROM_LAT     = 2
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [9:0]  src_x_in,
    input  logic [8:0]  src_y_in,
    input  logic [10:0] dst_x_in,
    input  logic [9:0]  dst_y_in,
    output logic [20:0] rom_addr_out,
    input  logic [7:0]  rom_data_in,
    output logic [16:0] fb_addr_out,
    output logic [7:0]  fb_data_out,
    output logic        fb_we_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [2:0]    drain_q, drain_d;
    logic [9:0]    src_x_q, src_x_d;
    logic [8:0]    src_y_q, src_y_d;
    logic [10:0]   dst_x_q, dst_x_d;
    logic [9:0]    dst_y_q, dst_y_d;
    logic [20:0]   rom_addr_q, rom_addr_d;

    // Stage 0 lines up with rom_addr_out; stage ROM_LAT lines up with rom_data_in.
    logic          pv_q [0:ROM_LAT];
    logic [CW-1:0] pc_q [0:ROM_LAT];
    logic [RW-1:0] pr_q [0:ROM_LAT];

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        drain_d    = drain_q;
        src_x_d    = src_x_q;
        src_y_d    = src_y_q;
        dst_x_d    = dst_x_q;
        dst_y_d    = dst_y_q;
        rom_addr_d = rom_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    src_x_d = src_x_in;
                    src_y_d = src_y_in;
                    dst_x_d = dst_x_in;
                    dst_y_d = dst_y_in;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rom_addr_d = 21'(src_x_q) + 21'(col_q)
                           + (21'(src_y_q) + 21'(row_q)) * 21'(SHEET_WIDTH);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            // Stays until the final sample has left the ROM pipeline.
            S_DRAIN: begin
                if (drain_q == 3'(ROM_LAT)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            src_x_q    <= '0;
            src_y_q    <= '0;
            dst_x_q    <= '0;
            dst_y_q    <= '0;
            rom_addr_q <= '0;
            for (int unsigned i = 0; i <= ROM_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pc_q[i] <= '0;
                pr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            src_x_q    <= src_x_d;
            src_y_q    <= src_y_d;
            dst_x_q    <= dst_x_d;
            dst_y_q    <= dst_y_d;
            rom_addr_q <= rom_addr_d;
            pv_q[0]    <= (state_q == S_READ);
            pc_q[0]    <= col_q;
            pr_q[0]    <= row_q;
            for (int unsigned i = 1; i <= ROM_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pc_q[i] <= pc_q[i-1];
                pr_q[i] <= pr_q[i-1];
            end
        end
    end

    logic [11:0] fx, fy;
    logic        in_range, opaque, smp_valid;

    always_comb begin
        smp_valid = pv_q[ROM_LAT];
        fx        = 12'(dst_x_q) + 12'(pc_q[ROM_LAT]);
        fy        = 12'(dst_y_q) + 12'(pr_q[ROM_LAT]);
        in_range  = (fx < 12'(FB_WIDTH)) && (fy < 12'(FB_HEIGHT));
`ifdef BLIT_TRANSPARENCY_EN
        opaque    = (rom_data_in != 8'h00);
`else
        opaque    = 1'b1;
`endif
        fb_we_out   = smp_valid && in_range && opaque;
        fb_addr_out = smp_valid ? (17'(fx) + 17'(fy) * 17'(FB_WIDTH)) : '0;
        fb_data_out = smp_valid ? rom_data_in : '0;
    end

    assign rom_addr_out = rom_addr_q;
    assign busy_out     = (state_q != S_IDLE);
    assign done_out     = (state_q == S_DONE);

endmodule

// File: doc/sprite_blit_writer.md
SPRITE_BLIT_WRITER -- requirements
Module: sprite_blit_writer

Interface
REQ-001 SHALL have parameter SHEET_WIDTH, default 926: sprite-sheet row pitch in pixels.
REQ-002 SHALL have parameter SPR_W, default 64: blit width in pixels.
REQ-003 SHALL have parameter SPR_H, default 64: blit height in pixels.
REQ-004 SHALL have parameter FB_WIDTH, default 320: framebuffer width in pixels.
REQ-005 SHALL have parameter FB_HEIGHT, default 240: framebuffer height in pixels.
REQ-006 SHALL have parameter ROM_LAT, default 2: sheet ROM read latency in cycles (1..4).
REQ-007 SHALL have port pixel_clk_in, input, 1: the only clock; all logic on its rising edge.
REQ-008 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port start_in, input, 1: one-cycle request to start a blit.
REQ-010 SHALL have ports src_x_in [9:0] and src_y_in [8:0], input: sheet origin of the sprite.
REQ-011 SHALL have ports dst_x_in [10:0] and dst_y_in [9:0], input: framebuffer origin.
REQ-012 SHALL have port rom_addr_out, output, 21: sheet ROM address.
REQ-013 SHALL have port rom_data_in, input, 8: sheet ROM palette index, valid ROM_LAT cycles after its address.
REQ-014 SHALL have ports fb_addr_out [16:0], fb_data_out [7:0] and fb_we_out [1], output: framebuffer write port.
REQ-015 SHALL have ports busy_out [1] and done_out [1], output: blit in progress; one-cycle completion pulse.

Function
REQ-016 SHALL capture src/dst inputs when start_in=1 in IDLE; inputs are ignored at all other times.
REQ-017 SHALL ignore start_in while busy_out=1; no queuing.
REQ-018 SHALL implement FSM IDLE -> READ (on start) -> DRAIN (after last address issued) -> DONE (after ROM_LAT drain cycles) -> IDLE (after one cycle).
REQ-019 SHALL in READ issue one address per cycle, raster order, col 0..SPR_W-1 inner, row 0..SPR_H-1 outer: rom_addr_out = (src_x+col) + (src_y+row)*SHEET_WIDTH, computed at 21 bits with no truncation.
REQ-020 SHALL carry col/row and a valid bit through a ROM_LAT-deep shift register aligned to rom_data_in.
REQ-021 SHALL assert fb_we_out for exactly one cycle per aligned sample, with fb_addr_out = (dst_x+col) + (dst_y+row)*FB_WIDTH and fb_data_out = rom_data_in.
REQ-022 SHALL suppress fb_we_out (clip) when dst_x+col >= FB_WIDTH or dst_y+row >= FB_HEIGHT, using 12-bit compares with no wrap-around.
REQ-023 SHALL take exactly SPR_W*SPR_H + ROM_LAT + 1 cycles from the start-capture edge to the done_out pulse.
REQ-024 SHALL hold busy_out=1 in READ, DRAIN and DONE, and 0 in IDLE.
REQ-025 SHALL pulse done_out=1 for exactly one cycle, in DONE.
REQ-026 SHALL accept start_in in the cycle immediately after DONE (back-to-back blits).
REQ-027 SHALL drive fb_we_out=0 in IDLE and in DONE.

Reset
REQ-028 SHALL on rst_in=1 force state IDLE, clear counters and all pipeline valid bits, and set busy_out=0, done_out=0, fb_we_out=0, rom_addr_out=0, fb_addr_out=0, fb_data_out=0.
REQ-029 SHALL on reset mid-blit abort at once: no fb_we_out from the next edge on, no done_out pulse.
REQ-030 SHALL give rst_in priority over start_in in the same cycle.

Configuration
REQ-031 SHALL, with macro BLIT_TRANSPARENCY_EN defined, suppress fb_we_out for samples where rom_data_in == 8'h00 (transparent key); cycle timing is unchanged.
REQ-032 SHALL, without BLIT_TRANSPARENCY_EN, write index 0 like any other value.

Verification
REQ-033 SHALL cover: SPR_W=SPR_H=4, ROM_LAT=2, src=(10,3), dst=(0,0), start -> 16 writes to fb_addr 0..3, 320..323, 640..643, 960..963 with data = ROM[2788+col+row*926]; done_out at cycle 19.
REQ-034 SHALL cover: dst=(318,238), 4x4 -> only 4 writes (cols 0-1, rows 0-1); done_out timing unchanged.
REQ-035 SHALL cover: start_in pulsed again at cycle 5 of a blit -> ignored; exactly 16 writes, one done_out pulse.
REQ-036 SHALL cover: rst_in at cycle 8 -> fb_we_out=0 from cycle 9 on, busy_out=0, no done_out; a new start then gives a full 16-write blit.
REQ-037 SHALL cover: BLIT_TRANSPARENCY_EN defined and ROM words 0 at cols 1 and 3 -> those 8 writes suppressed; 8 writes occur; done_out still at cycle 19.
REQ-038 SHALL cover: start_in on the cycle after done_out -> second blit begins with no idle gap and its first write 3 cycles later.
